frog_hazard_judge: RTL

Parametrised, frame-sequenced collision judge for the Frogger playfield. Once per frame it snapshots the frog, hazard (car) and log occupancy grids. It then scans one row per clock: on road rows, frog-on-hazard is a hit; on river rows, a frog not fully on a log is a hit. It also maintains a post-hit grace window, a lives counter and a sticky game-over flag, which the game controller uses in place of a raw per-cycle reset pulse.

---
 rtl/frog_hazard_judge.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/frog_hazard_judge.sv
// frog_hazard_judge
//   Frame-sequenced collision judge for the Frogger playfield. On frame_tick
//   the frog, hazard and log grids plus the river mask are snapshotted, then
//   one row is scanned per clock. Road rows hit on frog-over-hazard, river
//   rows hit when any frog cell is not over a log. The lowest hitting row is
//   reported. A counted hit costs a life and opens a grace window of GRACE
//   frames. Reaching zero lives sets a sticky game_over.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   frame_tick  one-cycle frame evaluation request (ignored while busy)
//   frog        frog occupancy grid   [ROWS][COLS]
//   hazard      car occupancy grid    [ROWS][COLS]
//   logs        log occupancy grid    [ROWS][COLS]
//   river_mask  per-row 1 = river rule, 0 = road rule
//   busy        frame evaluation in progress
//   hit         one-cycle pulse on a counted life loss
//   hit_row     lowest row that caused the counted hit
//   hit_kind    0 = squashed (road), 1 = drowned (river)
//   lives       remaining lives
//   game_over   sticky, set when lives reach zero
module frog_hazard_judge #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int LIVES = 3,
  parameter int GRACE = 4,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int LW = $clog2(LIVES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic [ROWS-1:0][COLS-1:0]  frog,
  input  logic [ROWS-1:0][COLS-1:0]  hazard,
  input  logic [ROWS-1:0][COLS-1:0]  logs,
  input  logic [ROWS-1:0]            river_mask,
  output logic                       busy,
  output logic                       hit,
  output logic [RW-1:0]              hit_row,
  output logic                       hit_kind,
  output logic [LW-1:0]              lives,
  output logic                       game_over
);

  // grace counter needs at least one bit even when GRACE is 0
  localparam int GW = (GRACE > 0) ? $clog2(GRACE + 1) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

  state_t                     state;
  logic [ROWS-1:0][COLS-1:0]  frog_snap;
  logic [ROWS-1:0][COLS-1:0]  hazard_snap;
  logic [ROWS-1:0][COLS-1:0]  logs_snap;
  logic [ROWS-1:0]            river_snap;
  logic [RW-1:0]              row;
  logic                       found;
  logic [RW-1:0]              found_row;
  logic                       found_kind;
  logic [GW-1:0]              grace_cnt;
  logic                       row_hit;
  logic                       counted;

  always_comb begin
    row_hit = 1'b0;
    if (river_snap[row])
      row_hit = |(frog_snap[row] & ~logs_snap[row]);
    else
      row_hit = |(frog_snap[row] & hazard_snap[row]);
  end

  // lives != 0 is implied by !game_over; kept as an explicit underflow guard
  assign counted = found && (grace_cnt == '0) && !game_over && (lives != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      hit         <= 1'b0;
      hit_row     <= '0;
      hit_kind    <= 1'b0;
      lives       <= LW'(LIVES);
      game_over   <= 1'b0;
      grace_cnt   <= '0;
      frog_snap   <= '0;
      hazard_snap <= '0;
      logs_snap   <= '0;
      river_snap  <= '0;
      row         <= '0;
      found       <= 1'b0;
      found_row   <= '0;
      found_kind  <= 1'b0;
    end else begin
      hit <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            frog_snap   <= frog;
            hazard_snap <= hazard;
            logs_snap   <= logs;
            river_snap  <= river_mask;
            row         <= '0;
            found       <= 1'b0;
            busy        <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          // first hit wins, so the reported row is the lowest index
          if (row_hit && !found) begin
            found      <= 1'b1;
            found_row  <= row;
            found_kind <= river_snap[row];
          end
          if (row == RW'(ROWS - 1))
            state <= DECIDE;
          else
            row <= row + 1'b1;
        end
        DECIDE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (counted) begin
            hit       <= 1'b1;
            hit_row   <= found_row;
            hit_kind  <= found_kind;
            lives     <= lives - 1'b1;
            grace_cnt <= GW'(GRACE);
            if (lives == LW'(1))
              game_over <= 1'b1;
          end else if (grace_cnt != '0) begin
            grace_cnt <= grace_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
